// File: rtl/game_pkg.sv
// Shared game constants, map-generator state type and small helpers.
package game_pkg;

  localparam int CELLS_X   = 32;
  localparam int CELLS_Y   = 24;
  localparam int CELL_SIZE = 32;
  localparam int N_CELLS   = CELLS_X * CELLS_Y;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;

  typedef enum logic [0:0] {MG_IDLE, MG_FILL} map_gen_state_t;

  typedef logic [4:0] coord_t;
  typedef logic [9:0] cell_idx_t;

  // Linear RAM address of a cell, raster order with x fastest.
  function automatic cell_idx_t cell_index(coord_t cx, coord_t cy);
    return cell_idx_t'(cy) * cell_idx_t'(CELLS_X) + cell_idx_t'(cx);
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/map_lfsr.sv
// 16-bit Galois LFSR with seed load, step enable and zero-seed substitution.
module map_lfsr
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [3:0]  nib
);

  logic [15:0] q;

  // State register: reset to default, load wins over stepping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_DEFAULT;
    end else if (load) begin
      q <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

  assign nib = q[3:0];

endmodule

// File: rtl/map_generate.sv
// Occupancy-map generator: fills a CELLS_X x CELLS_Y bit map from a seeded
// LFSR, forces a solid border and a free spawn cross, and serves a
// synchronous read port to the renderer.
module map_generate
  import game_pkg::*;
#(
  parameter int DENSITY = 4,
  parameter int SPAWN_X = 1,
  parameter int SPAWN_Y = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  output logic        busy,
  output logic        done,
  output logic        map_valid,
  output logic [9:0]  solid_cnt,
  input  logic [4:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic        rd_data
);

  localparam coord_t X_LAST = coord_t'(CELLS_X - 1);
  localparam coord_t Y_LAST = coord_t'(CELLS_Y - 1);

  map_gen_state_t state, state_next;
  coord_t         x, y;
  logic [9:0]     cnt;
  logic [3:0]     rnd;
  logic           cell_bit;
  logic           accept;
  logic           fill_last;
  logic           rd_in_range;
  cell_idx_t      wr_idx;
  cell_idx_t      rd_idx;

  logic mem [N_CELLS];

  // Spawn cross beats border, border beats the random draw.
  function automatic logic cell_value(coord_t cx, coord_t cy, logic [3:0] r);
    int dx, dy;
    dx = int'(cx) - SPAWN_X;
    dy = int'(cy) - SPAWN_Y;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    if (dx + dy <= 1) return 1'b0;
    if (cx == '0 || cx == X_LAST || cy == '0 || cy == Y_LAST) return 1'b1;
    return int'(r) < DENSITY;
  endfunction

  map_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state == MG_FILL),
    .seed (seed),
    .nib  (rnd)
  );

  assign accept      = (state == MG_IDLE) && start;
  assign fill_last   = (state == MG_FILL) && (x == X_LAST) && (y == Y_LAST);
  assign cell_bit    = cell_value(x, y, rnd);
  assign wr_idx      = cell_index(x, y);
  assign rd_idx      = cell_index(rd_x, rd_y);
  assign rd_in_range = ({1'b0, rd_x} < 6'(CELLS_X)) && ({1'b0, rd_y} < 6'(CELLS_Y));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= MG_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      MG_IDLE: if (start)     state_next = MG_FILL;
      MG_FILL: if (fill_last) state_next = MG_IDLE;
      default:                state_next = MG_IDLE;
    endcase
  end

  // Fill cursor, running count and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      map_valid <= 1'b0;
      solid_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        x         <= '0;
        y         <= '0;
        cnt       <= '0;
        busy      <= 1'b1;
        map_valid <= 1'b0;
      end else if (state == MG_FILL) begin
        cnt <= cnt + 10'(cell_bit);
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 5'd1;
        end else begin
          x <= x + 5'd1;
        end
        if (fill_last) begin
          busy      <= 1'b0;
          done      <= 1'b1;
          map_valid <= 1'b1;
          solid_cnt <= cnt + 10'(cell_bit);
        end
      end
    end
  end

  // Map RAM write port, one cell per FILL cycle.
  // NOTE: the RAM array has no reset so it maps onto block RAM; map_valid
  // tells consumers when its contents mean anything.
  always_ff @(posedge clk) begin
    if (!rst && state == MG_FILL) mem[wr_idx] <= cell_bit;
  end

  // Registered read port; out-of-map coordinates read as free.
  always_ff @(posedge clk) begin
    if (rst)              rd_data <= 1'b0;
    else if (rd_in_range) rd_data <= mem[rd_idx];
    else                  rd_data <= 1'b0;
  end

endmodule

// File: tb/tb_map_generate.sv
// Self-checking bench for map_generate against a cycle-level behavioural model.
module tb_map_generate;

  localparam int NX   = 32;
  localparam int NY   = 24;
  localparam int NC   = NX * NY;
  localparam int DENS = 4;
  localparam int SPX  = 1;
  localparam int SPY  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [4:0]  rd_x = 5'd0;
  logic [4:0]  rd_y = 5'd0;

  logic        busy, done, map_valid, rd_data;
  logic [9:0]  solid_cnt;
  logic        z_busy, z_done, z_map_valid, z_rd_data;
  logic [9:0]  z_solid_cnt;

  map_generate dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy), .done(done), .map_valid(map_valid), .solid_cnt(solid_cnt),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
  );

  map_generate #(.DENSITY(0)) dut_empty (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(z_busy), .done(z_done), .map_valid(z_map_valid), .solid_cnt(z_solid_cnt),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(z_rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          m_init = 0;
  bit          m_busy, m_done, m_valid, m_rd, m_rd_known;
  int          m_cnt, m_acc, m_rem;
  logic [15:0] m_lfsr;
  bit          m_ram [NC];
  bit          m_kn  [NC];

  function automatic bit model_cell(int k, logic [15:0] l);
    int cx, cy, dx, dy;
    cx = k % NX;
    cy = k / NX;
    dx = (cx > SPX) ? cx - SPX : SPX - cx;
    dy = (cy > SPY) ? cy - SPY : SPY - cy;
    if (dx + dy <= 1) return 1'b0;
    if (cx == 0 || cx == NX - 1 || cy == 0 || cy == NY - 1) return 1'b1;
    return int'(l & 16'h000F) < DENS;
  endfunction

  function automatic logic [15:0] model_step(logic [15:0] l);
    return (l >> 1) ^ ((l & 16'h1) != 0 ? 16'hB400 : 16'h0);
  endfunction

  // Advance the model by one clock using the inputs seen at this edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_init = 1; m_busy = 0; m_done = 0; m_valid = 0; m_cnt = 0;
      m_rd = 0; m_rd_known = 1; m_rem = 0;
    end else begin
      if (int'(rd_y) >= NY) begin
        m_rd = 0; m_rd_known = 1;
      end else begin
        m_rd       = m_ram[int'(rd_y) * NX + int'(rd_x)];
        m_rd_known = m_kn[int'(rd_y) * NX + int'(rd_x)];
      end
      m_done = 0;
      if (m_rem > 0) begin
        automatic int k = NC - m_rem;
        automatic bit v = model_cell(k, m_lfsr);
        m_ram[k] = v;
        m_kn[k]  = 1;
        m_acc   += int'(v);
        m_lfsr   = model_step(m_lfsr);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_valid = 1; m_cnt = m_acc;
        end
      end else if (start) begin
        m_lfsr  = (seed == 16'h0) ? 16'hACE1 : seed;
        m_rem   = NC;
        m_busy  = 1;
        m_valid = 0;
        m_acc   = 0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("busy",      32'(busy),      32'(m_busy));
      check("done",      32'(done),      32'(m_done));
      check("map_valid", 32'(map_valid), 32'(m_valid));
      check("solid_cnt", 32'(solid_cnt), 32'(m_cnt));
      if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  bit cap   [NC];
  bit cap_a [NC];
  bit cap_b [NC];

  task automatic pulse_start(logic [15:0] s);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int bound);
    bit got = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    check("done_within_bound", 32'(got), 32'd1);
  endtask

  task automatic readback();
    for (int i = 0; i < NC; i++) begin
      rd_x = 5'(i % NX);
      rd_y = 5'(i / NX);
      @(negedge clk);
      cap[i] = rd_data;
    end
  endtask

  task automatic read_cell(int cx, int cy, output logic v);
    rd_x = 5'(cx);
    rd_y = 5'(cy);
    @(negedge clk);
    v = rd_data;
  endtask

  function automatic int diff_count(bit a [NC], bit b [NC]);
    int d = 0;
    for (int i = 0; i < NC; i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int   t0, n_done, done_at;
    logic v;

    // Model pins: first LFSR steps from the default seed.
    check("model_step_ace1", 32'(model_step(16'hACE1)), 32'h0000E270);
    check("model_step_e270", 32'(model_step(16'hE270)), 32'h00007138);

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_map_valid", 32'(map_valid), 32'd0);
    check("rst_solid_cnt", 32'(solid_cnt), 32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Seed 1234: latency, full readback, fixed cells.
    pulse_start(16'h1234);
    t0 = cyc;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(2000);
    check("fill_latency", 32'(cyc - t0), 32'd768);
    check("empty_solid_cnt", 32'(z_solid_cnt), 32'd106);
    readback();
    cap_a = cap;
    read_cell(0, 5,  v); check("border_left",   32'(v), 32'd1);
    read_cell(31, 7, v); check("border_right",  32'(v), 32'd1);
    read_cell(9, 0,  v); check("border_top",    32'(v), 32'd1);
    read_cell(20, 23, v); check("border_bottom", 32'(v), 32'd1);
    read_cell(1, 1,  v); check("spawn_11",      32'(v), 32'd0);
    read_cell(0, 1,  v); check("spawn_01",      32'(v), 32'd0);
    read_cell(1, 0,  v); check("spawn_10",      32'(v), 32'd0);
    read_cell(2, 1,  v); check("spawn_21",      32'(v), 32'd0);
    read_cell(1, 2,  v); check("spawn_12",      32'(v), 32'd0);
    read_cell(3, 30, v); check("out_of_range",  32'(v), 32'd0);

    // Zero seed behaves like the default seed.
    pulse_start(16'hACE1);
    wait_done(2000);
    readback();
    cap_b = cap;
    pulse_start(16'h0000);
    wait_done(2000);
    readback();
    check("seed0_equals_ace1", 32'(diff_count(cap, cap_b)), 32'd0);

    // Extra start pulses during a fill are ignored.
    pulse_start(16'h5A5A);
    n_done  = 0;
    done_at = 0;
    for (int c = 1; c <= 900; c++) begin
      start = (c == 10 || c == 400);
      @(negedge clk);
      if (done) begin
        n_done++;
        done_at = c;
      end
    end
    start = 1'b0;
    check("one_done_pulse", 32'(n_done),  32'd1);
    check("done_at_768",    32'(done_at), 32'd768);

    // Start on the final write cycle is ignored; start on done is accepted.
    pulse_start(16'hBEEF);
    for (int i = 0; i < 2000; i++) begin
      start = (m_rem == 1);
      @(negedge clk);
      if (done) break;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_accepted", 32'(busy), 32'd1);
    wait_done(2000);

    // Reset mid-fill, then regenerate seed 1234.
    pulse_start(16'h1234);
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_map_valid", 32'(map_valid), 32'd0);
    pulse_start(16'h1234);
    wait_done(2000);
    readback();
    check("regen_same_map", 32'(diff_count(cap, cap_a)), 32'd0);

    // Randomized seeds, start pulses and read addresses.
    for (int r = 0; r < 4; r++) begin
      pulse_start(16'($urandom));
      for (int i = 0; i < 900; i++) begin
        start = ($urandom_range(0, 60) == 0);
        if ($urandom_range(0, 7) == 0) seed = 16'($urandom);
        rd_x = 5'($urandom);
        rd_y = 5'($urandom_range(0, 31));
        @(negedge clk);
      end
      start = 1'b0;
    end
    repeat (800) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
